// File: rtl/latency_stats_mc.sv
// latency_stats_mc: per-channel start->stop latency monitor with windowed max/min/sum/count,
// a global snapshot into latched registers, and a registered per-channel readout port.
module latency_stats_mc #(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 32,
    parameter  int ACC_W  = 48,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] start_i,
    input  logic [NUM_CH-1:0] stop_i,
    input  logic              snap_i,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic [CNT_W-1:0]  rd_max_o,
    output logic [CNT_W-1:0]  rd_min_o,
    output logic [ACC_W-1:0]  rd_sum_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [2:0]        rd_flags_o
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    // Result is {overflowed, clamped sum}; the sample is zero-extended to the accumulator width.
    function automatic logic [ACC_W:0] sum_sat_add(input logic [ACC_W-1:0] acc,
                                                   input logic [CNT_W-1:0] s);
        logic [ACC_W:0] full;
        full = {1'b0, acc} + {{(ACC_W + 1 - CNT_W){1'b0}}, s};
        if (full[ACC_W]) begin
            return {1'b1, ACC_MAX};
        end
        return full;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    state_e           state_q   [NUM_CH];
    state_e           state_d   [NUM_CH];
    logic [CNT_W-1:0] cur_q     [NUM_CH];
    logic [CNT_W-1:0] cur_d     [NUM_CH];
    logic [CNT_W-1:0] win_max_q [NUM_CH];
    logic [CNT_W-1:0] win_max_d [NUM_CH];
    logic [CNT_W-1:0] win_min_q [NUM_CH];
    logic [CNT_W-1:0] win_min_d [NUM_CH];
    logic [ACC_W-1:0] win_sum_q [NUM_CH];
    logic [ACC_W-1:0] win_sum_d [NUM_CH];
    logic [CNT_W-1:0] win_cnt_q [NUM_CH];
    logic [CNT_W-1:0] win_cnt_d [NUM_CH];
    logic [2:0]       win_flg_q [NUM_CH];
    logic [2:0]       win_flg_d [NUM_CH];
    logic [CNT_W-1:0] lat_max_q [NUM_CH];
    logic [CNT_W-1:0] lat_max_d [NUM_CH];
    logic [CNT_W-1:0] lat_min_q [NUM_CH];
    logic [CNT_W-1:0] lat_min_d [NUM_CH];
    logic [ACC_W-1:0] lat_sum_q [NUM_CH];
    logic [ACC_W-1:0] lat_sum_d [NUM_CH];
    logic [CNT_W-1:0] lat_cnt_q [NUM_CH];
    logic [CNT_W-1:0] lat_cnt_d [NUM_CH];
    logic [2:0]       lat_flg_q [NUM_CH];
    logic [2:0]       lat_flg_d [NUM_CH];

    logic [CNT_W-1:0] rd_max_q, rd_max_d;
    logic [CNT_W-1:0] rd_min_q, rd_min_d;
    logic [ACC_W-1:0] rd_sum_q, rd_sum_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [2:0]       rd_flg_q, rd_flg_d;

    always_comb begin
        logic             commit;
        logic [CNT_W-1:0] smp;
        logic             perr;
        logic             lsat;
        logic [ACC_W:0]   sum_res;
        logic [CNT_W-1:0] c_max;
        logic [CNT_W-1:0] c_min;
        logic [CNT_W-1:0] c_cnt;
        logic [2:0]       c_flg;
        for (int i = 0; i < NUM_CH; i++) begin
            commit      = 1'b0;
            smp         = '0;
            perr        = 1'b0;
            lsat        = 1'b0;
            state_d[i]  = state_q[i];
            cur_d[i]    = cur_q[i];
            case (state_q[i])
                IDLE: begin
                    if (start_i[i] && stop_i[i]) begin
                        commit = 1'b1;
                    end else if (start_i[i]) begin
                        state_d[i] = RUN;
                        cur_d[i]   = CNT_W'(1);
                    end else if (stop_i[i]) begin
                        perr = 1'b1;
                    end
                end
                RUN: begin
                    if (stop_i[i]) begin
                        commit = 1'b1;
                        smp    = cur_q[i];
                        if (start_i[i]) begin
                            cur_d[i] = CNT_W'(1);
                        end else begin
                            state_d[i] = IDLE;
                            cur_d[i]   = '0;
                        end
                    end else begin
                        perr     = start_i[i];
                        lsat     = (cur_q[i] == CNT_MAX);
                        cur_d[i] = cnt_sat_inc(cur_q[i]);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cur_d[i]   = '0;
                end
            endcase

            c_max   = (commit && (smp > win_max_q[i])) ? smp : win_max_q[i];
            c_min   = (commit && (smp < win_min_q[i])) ? smp : win_min_q[i];
            sum_res = commit ? sum_sat_add(win_sum_q[i], smp) : {1'b0, win_sum_q[i]};
            c_cnt   = commit ? cnt_sat_inc(win_cnt_q[i]) : win_cnt_q[i];
            c_flg   = win_flg_q[i] | {perr, sum_res[ACC_W], lsat};

            // Snapshot captures the window including this cycle's commit and flags, then reopens it.
            if (snap_i) begin
                lat_max_d[i] = c_max;
                lat_min_d[i] = (c_cnt == '0) ? '0 : c_min;
                lat_sum_d[i] = sum_res[ACC_W-1:0];
                lat_cnt_d[i] = c_cnt;
                lat_flg_d[i] = c_flg;
                win_max_d[i] = '0;
                win_min_d[i] = '1;
                win_sum_d[i] = '0;
                win_cnt_d[i] = '0;
                win_flg_d[i] = '0;
            end else begin
                lat_max_d[i] = lat_max_q[i];
                lat_min_d[i] = lat_min_q[i];
                lat_sum_d[i] = lat_sum_q[i];
                lat_cnt_d[i] = lat_cnt_q[i];
                lat_flg_d[i] = lat_flg_q[i];
                win_max_d[i] = c_max;
                win_min_d[i] = c_min;
                win_sum_d[i] = sum_res[ACC_W-1:0];
                win_cnt_d[i] = c_cnt;
                win_flg_d[i] = c_flg;
            end
        end
    end

    always_comb begin
        rd_max_d = '0;
        rd_min_d = '0;
        rd_sum_d = '0;
        rd_cnt_d = '0;
        rd_flg_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch_i == CH_W'(i)) begin
                rd_max_d = lat_max_q[i];
                rd_min_d = lat_min_q[i];
                rd_sum_d = lat_sum_q[i];
                rd_cnt_d = lat_cnt_q[i];
                rd_flg_d = lat_flg_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]   <= IDLE;
                cur_q[i]     <= '0;
                win_max_q[i] <= '0;
                win_min_q[i] <= '1;
                win_sum_q[i] <= '0;
                win_cnt_q[i] <= '0;
                win_flg_q[i] <= '0;
                lat_max_q[i] <= '0;
                lat_min_q[i] <= '0;
                lat_sum_q[i] <= '0;
                lat_cnt_q[i] <= '0;
                lat_flg_q[i] <= '0;
            end
            rd_max_q <= '0;
            rd_min_q <= '0;
            rd_sum_q <= '0;
            rd_cnt_q <= '0;
            rd_flg_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            win_max_q <= win_max_d;
            win_min_q <= win_min_d;
            win_sum_q <= win_sum_d;
            win_cnt_q <= win_cnt_d;
            win_flg_q <= win_flg_d;
            lat_max_q <= lat_max_d;
            lat_min_q <= lat_min_d;
            lat_sum_q <= lat_sum_d;
            lat_cnt_q <= lat_cnt_d;
            lat_flg_q <= lat_flg_d;
            rd_max_q  <= rd_max_d;
            rd_min_q  <= rd_min_d;
            rd_sum_q  <= rd_sum_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_flg_q  <= rd_flg_d;
        end
    end

    assign rd_max_o   = rd_max_q;
    assign rd_min_o   = rd_min_q;
    assign rd_sum_o   = rd_sum_q;
    assign rd_cnt_o   = rd_cnt_q;
    assign rd_flags_o = rd_flg_q;
endmodule
